pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and one reset: clk_i  in  1  rising-edge clock; rst_i  in  1  asynchronous, active-low reset.
REQ-002 SHALL have IFID_rs_i  in  5  rs field of the instruction in IF/ID.
REQ-003 SHALL have IFID_rt_i  in  5  rt field of the instruction in IF/ID.
REQ-004 SHALL have IDEX_MemRead_i  in  1  the instruction in ID/EX is a load; IDEX_rt_i  in  5  load destination register.
REQ-005 SHALL have EXMEM_Branch_i  in  1  branch in EX/MEM; EXMEM_zero_i  in  1  ALU zero flag in EX/MEM.
REQ-006 SHALL have EXMEM_MemAccess_i  in  1  EX/MEM holds a load or store; dmem_ready_i  in  1  data memory completes the access this cycle.
REQ-007 SHALL have dmem_req_o  out  1  data memory request; pc_write_o  out  1  PC enable; pc_src_o  out  1  select branch target.
REQ-008 SHALL have ifid_write_o, idex_write_o, exmem_write_o  out  1 each  pipeline register enables.
REQ-009 SHALL have ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_bubble_o  out  1 each  load zeros or control bubble.
REQ-010 SHALL have state_o  out  2  FSM state; stall_cnt_o  out  16  stall cycles; timeout_o  out  1  sticky memory timeout.
REQ-011 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum MEM_WAIT cycles before timeout_o is set.

Function
REQ-012 SHALL implement the FSM states RUN=0, LOAD_STALL=1, MEM_WAIT=2; encoding 3 is unused and SHALL return to RUN.
REQ-013 SHALL define mem_stall = EXMEM_MemAccess_i & ~dmem_ready_i; dmem_req_o = EXMEM_MemAccess_i in RUN, LOAD_STALL and MEM_WAIT.
REQ-014 SHALL, while mem_stall, drive pc_write/ifid_write/idex_write/exmem_write=0 and memwb_bubble=1, and assert no flush.
REQ-015 SHALL, while mem_stall, go to or remain in MEM_WAIT; when dmem_ready_i rises, return to RUN on the next edge.
REQ-016 SHALL define branch_taken = EXMEM_Branch_i & EXMEM_zero_i & ~mem_stall.
REQ-017 SHALL, on branch_taken, in the same cycle drive pc_src=1, pc_write=1 and ifid_flush=idex_flush=exmem_flush=1; branch_taken overrides load-use.
REQ-018 SHALL define load_use = IDEX_MemRead_i & (IDEX_rt_i!=0) & (IDEX_rt_i==IFID_rs_i | IDEX_rt_i==IFID_rt_i).
REQ-019 SHALL, on load_use in RUN without mem_stall/branch_taken, drive pc_write=0, ifid_write=0, idex_flush=1 and go to LOAD_STALL.
REQ-020 SHALL leave LOAD_STALL for RUN after exactly one cycle and ignore load_use during LOAD_STALL.
REQ-021 SHALL use the priority mem_stall > branch_taken > load_use; all enables are 1 and all flushes are 0 otherwise.
REQ-022 SHALL increment stall_cnt_o by one each cycle in which pc_write_o=0, saturating at 16'hFFFF.
REQ-023 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter cleared on leaving MEM_WAIT, setting timeout_o when the count reaches MEM_TIMEOUT.
REQ-024 SHALL keep timeout_o set until reset and SHALL NOT let it alter the stall behaviour.

Reset
REQ-025 SHALL, while rst_i=0, asynchronously force state=RUN, stall_cnt_o=0, the wait counter=0 and timeout_o=0.
REQ-026 SHALL drive the combinational outputs from RUN with no hazard during reset: enables=1, flushes=0, dmem_req_o=EXMEM_MemAccess_i.
REQ-027 SHALL, on reset during MEM_WAIT or LOAD_STALL, abandon the stall and resume in RUN on the first edge after rst_i rises.

Structure
REQ-028 SHALL place the state encodings, the MEM_TIMEOUT default and the counter widths in a shared package pipe_pkg.
REQ-029 SHALL implement hazard detection (load_use, branch_taken) in one combinational sub-module hazard_detect; the FSM and counters stay in the top module.

Verification
REQ-030 SHALL check load-use: IDEX_MemRead_i=1, IDEX_rt_i=5, IFID_rs_i=5 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1, state 0->1->0, stall_cnt=1.
REQ-031 SHALL check rt=0: IDEX_rt_i=0, IFID_rs_i=0, MemRead=1 -> no stall.
REQ-032 SHALL check branch flush: Branch=1, zero=1 -> pc_src=1 and three flushes for one cycle, with no stall counted.
REQ-033 SHALL check memory wait: MemAccess=1, ready low for 3 cycles then high -> all writes 0 for 3 cycles, state=2, stall_cnt=3, then RUN.
REQ-034 SHALL check timeout: MEM_TIMEOUT=4, ready low for 6 cycles -> timeout_o=1 after the 4th wait cycle, still 1 after recovery, and cleared only by rst_i=0.
REQ-035 SHALL check simultaneous events: mem_stall+branch+load_use together -> pure stall with no flush; on ready, branch flush applies.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings, counter widths and defaults for pipeline_ctrl
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } pipe_state_e;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int          STALL_CNT_W     = 16;
    localparam int          WAIT_CNT_W      = 8;
    localparam int          REG_ADDR_W      = 5;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and taken-branch detection
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] IFID_rs_i,
    input  logic [REG_ADDR_W-1:0] IFID_rt_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_rt_i,
    input  logic                  EXMEM_Branch_i,
    input  logic                  EXMEM_zero_i,
    input  logic                  mem_stall_i,
    output logic                  load_use_o,
    output logic                  branch_taken_o
);

    // A load writing r0 never creates a dependency, since r0 is hardwired to zero.
    assign load_use_o = IDEX_MemRead_i
                      & (IDEX_rt_i != '0)
                      & ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i));

    // A frozen pipeline cannot redirect, so a memory stall masks the branch.
    assign branch_taken_o = EXMEM_Branch_i & EXMEM_zero_i & ~mem_stall_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard control FSM with stall and memory-timeout counters
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_ADDR_W-1:0]  IFID_rs_i,
    input  logic [REG_ADDR_W-1:0]  IFID_rt_i,
    input  logic                   IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  IDEX_rt_i,
    input  logic                   EXMEM_Branch_i,
    input  logic                   EXMEM_zero_i,
    input  logic                   EXMEM_MemAccess_i,
    input  logic                   dmem_ready_i,
    output logic                   dmem_req_o,
    output logic                   pc_write_o,
    output logic                   pc_src_o,
    output logic                   ifid_write_o,
    output logic                   idex_write_o,
    output logic                   exmem_write_o,
    output logic                   ifid_flush_o,
    output logic                   idex_flush_o,
    output logic                   exmem_flush_o,
    output logic                   memwb_bubble_o,
    output logic [1:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   timeout_o
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    pipe_state_e            state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;

    logic mem_stall;
    logic load_use;
    logic branch_taken;

    assign mem_stall  = EXMEM_MemAccess_i & ~dmem_ready_i;
    assign dmem_req_o = EXMEM_MemAccess_i;

    hazard_detect u_hazard_detect (
        .IFID_rs_i      (IFID_rs_i),
        .IFID_rt_i      (IFID_rt_i),
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_rt_i      (IDEX_rt_i),
        .EXMEM_Branch_i (EXMEM_Branch_i),
        .EXMEM_zero_i   (EXMEM_zero_i),
        .mem_stall_i    (mem_stall),
        .load_use_o     (load_use),
        .branch_taken_o (branch_taken)
    );

    // Pipeline enables and flushes; reset holds the pipeline in its free-running RUN form.
    always_comb begin
        pc_write_o     = 1'b1;
        pc_src_o       = 1'b0;
        ifid_write_o   = 1'b1;
        idex_write_o   = 1'b1;
        exmem_write_o  = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_flush_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        if (rst_i) begin
            if (mem_stall) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_write_o  = 1'b0;
                memwb_bubble_o = 1'b1;
            end else if (branch_taken) begin
                pc_src_o      = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
            end else if (load_use && (state_q == ST_RUN)) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end
        end
    end

    // Next state and counter values; the stray encoding 3 falls back to RUN.
    always_comb begin
        state_d = ST_RUN;
        if (mem_stall) begin
            state_d = ST_MEM_WAIT;
        end else begin
            case (state_q)
                ST_RUN:  state_d = (load_use && !branch_taken) ? ST_LOAD_STALL : ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        wait_cnt_d = '0;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        timeout_d = timeout_q | (mem_stall && (wait_cnt_d == TIMEOUT_CNT));
    end

    // State and counter registers, cleared asynchronously so a stall never survives reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  IFID_rs_i = '0, IFID_rt_i = '0, IDEX_rt_i = '0;
    logic        IDEX_MemRead_i = 1'b0, EXMEM_Branch_i = 1'b0, EXMEM_zero_i = 1'b0;
    logic        EXMEM_MemAccess_i = 1'b0, dmem_ready_i = 1'b1;
    logic        dmem_req_o, pc_write_o, pc_src_o;
    logic        ifid_write_o, idex_write_o, exmem_write_o;
    logic        ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_bubble_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic        timeout_o;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rt_i(IDEX_rt_i),
        .EXMEM_Branch_i(EXMEM_Branch_i), .EXMEM_zero_i(EXMEM_zero_i),
        .EXMEM_MemAccess_i(EXMEM_MemAccess_i), .dmem_ready_i(dmem_ready_i),
        .dmem_req_o(dmem_req_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .ifid_write_o(ifid_write_o), .idex_write_o(idex_write_o), .exmem_write_o(exmem_write_o),
        .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
        .memwb_bubble_o(memwb_bubble_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
    );

    typedef struct {
        logic [9:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: pipeline mode, stall total, length of current memory wait, sticky timeout.
    int m_st  = 0;
    int m_cnt = 0;
    int m_run = 0;
    bit m_to  = 1'b0;

    task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] ift,
                        input bit mr, input logic [4:0] xrt, input bit br, input bit z,
                        input bit acc, input bit rdy);
        exp_t e;
        bit ms, bt, lu;
        bit pw, ps, iw, dw, xw, ifl, idf, xf, bb;
        int nxt;
        @(posedge clk_i);
        #1;
        rst_i = rst;
        IFID_rs_i = rs; IFID_rt_i = ift; IDEX_MemRead_i = mr; IDEX_rt_i = xrt;
        EXMEM_Branch_i = br; EXMEM_zero_i = z; EXMEM_MemAccess_i = acc; dmem_ready_i = rdy;

        ms = acc && !rdy;
        bt = br && z && !ms;
        lu = mr && (xrt != 0) && ((xrt == rs) || (xrt == ift));
        pw = 1; ps = 0; iw = 1; dw = 1; xw = 1; ifl = 0; idf = 0; xf = 0; bb = 0;
        if (!rst) begin
            m_st = 0; m_cnt = 0; m_run = 0; m_to = 0;
        end else if (ms) begin
            pw = 0; iw = 0; dw = 0; xw = 0; bb = 1;
        end else if (bt) begin
            ps = 1; ifl = 1; idf = 1; xf = 1;
        end else if (lu && m_st == 0) begin
            pw = 0; iw = 0; idf = 1;
        end
        e.ctrl = {pw, ps, iw, dw, xw, ifl, idf, xf, bb, acc};
        e.st   = 2'(m_st);
        e.cnt  = 16'(m_cnt);
        e.to   = m_to;
        sb_q.push_back(e);

        if (rst) begin
            if (ms) nxt = 2;
            else if (m_st == 0 && lu && !bt) nxt = 1;
            else nxt = 0;
            if (!pw && m_cnt < 65535) m_cnt++;
            if (ms) begin
                if (m_run < 255) m_run++;
                if (m_run == TO) m_to = 1;
            end else begin
                m_run = 0;
            end
            m_st = nxt;
        end
    endtask

    // Monitor: compare every presented cycle against the oldest scoreboard entry.
    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                act = {pc_write_o, pc_src_o, ifid_write_o, idex_write_o, exmem_write_o,
                       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_bubble_o, dmem_req_o};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl t=%0t: got %b expected %b", $time, act, e.ctrl);
                end
                checks++;
                if (state_o !== e.st) begin
                    errors++;
                    $display("FAIL state t=%0t: got %0d expected %0d", $time, state_o, e.st);
                end
                checks++;
                if (stall_cnt_o !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t: got %0d expected %0d", $time, stall_cnt_o, e.cnt);
                end
                checks++;
                if (timeout_o !== e.to) begin
                    errors++;
                    $display("FAIL timeout t=%0t: got %b expected %b", $time, timeout_o, e.to);
                end
            end
        end
    end

    initial begin
        // reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // load-use on rs
        step(1, 5, 0, 1, 5, 0, 0, 0, 1);
        step(1, 5, 0, 1, 5, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // load to r0 never stalls
        step(1, 0, 0, 1, 0, 0, 0, 0, 1);
        // load-use on rt
        step(1, 1, 9, 1, 9, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // taken branch
        step(1, 0, 0, 0, 0, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 1);
        // memory wait of three cycles
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // timeout after four wait cycles, sticky until reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (6) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // memory stall, branch and load-use together
        step(1, 7, 0, 1, 7, 1, 1, 1, 0);
        step(1, 7, 0, 1, 7, 1, 1, 1, 0);
        step(1, 7, 0, 1, 7, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // randomized traffic with occasional reset, including reset mid-stall
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
